// File: rtl/sparse_oaram_encoder.sv
// sparse_oaram_encoder
//
// Takes the dense, row-major stream of signed activations for one channel
// tile and applies ReLU. It then zero-run-length encodes the result into the
// output-activation RAM (OARAM). Each OARAM entry holds a value and the number
// of zeros that precede it, which is the format the next layer's sparse fetch
// reads. A run that reaches MAX_RUN emits a (0, MAX_RUN) filler entry so
// the index field never overflows. Zeros after the last emitted entry produce
// no entry.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle pulse; starts a tile encode (only in IDLE)
//   in_valid/in_ready    input handshake (see below)
//   in_data, in_last     signed activation, last-element-of-tile marker
//   oaram_value          encoded value (non-negative after ReLU)
//   oaram_indices_value  zeros preceding this entry
//   oaram_address        write address
//   oaram_write_enable   one-cycle write strobe per entry
//   entry_count          entries written this tile (saturates at DEPTH)
//   done                 one-cycle pulse at tile completion
//   overflow             sticky: an entry was dropped because OARAM was full
//   state_dbg            current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state: it is high for the whole of RUN and
// never depends on in_valid. The producer may hold in_valid low for any number
// of cycles. Those gap cycles do not change the run counter or the address.
// The OARAM write side has no back-pressure. Every emitted entry is written
// exactly one cycle after the edge that accepted its beat.
module sparse_oaram_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int RAM_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic [DATA_WIDTH-1:0]  oaram_value,
  output logic [INDEX_WIDTH-1:0] oaram_indices_value,
  output logic [RAM_WIDTH-1:0]   oaram_address,
  output logic                   oaram_write_enable,
  output logic [RAM_WIDTH:0]     entry_count,
  output logic                   done,
  output logic                   overflow,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] MAX_RUN   = '1;
  // DEPTH expressed in entry_count's width (a single 1 in the MSB).
  localparam logic [RAM_WIDTH:0]     DEPTH_CNT = {1'b1, {RAM_WIDTH{1'b0}}};

  state_t                 state, next_state;
  logic [INDEX_WIDTH-1:0] run_cnt;
  logic                   accept;
  logic                   start_tile;
  logic [DATA_WIDTH-1:0]  relu_v;
  logic                   is_zero;
  logic                   emit;
  logic                   full;

  assign in_ready   = (state == RUN);
  assign accept     = in_valid && in_ready;
  assign start_tile = start && (state == IDLE);
  assign state_dbg  = state;

  assign relu_v  = in_data[DATA_WIDTH-1] ? '0 : in_data;
  assign is_zero = (relu_v == '0);
  // A zero beat emits only when the run is already at MAX_RUN. That zero is
  // folded into the filler entry.
  assign emit    = accept && (!is_zero || (run_cnt == MAX_RUN));
  assign full    = (entry_count == DEPTH_CNT);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (accept && in_last) next_state = DONE_S;
      DONE_S:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      run_cnt             <= '0;
      oaram_value         <= '0;
      oaram_indices_value <= '0;
      oaram_address       <= '0;
      oaram_write_enable  <= 1'b0;
      entry_count         <= '0;
      done                <= 1'b0;
      overflow            <= 1'b0;
    end else begin
      state              <= next_state;
      oaram_write_enable <= 1'b0;
      // Goes high on the edge that accepts the last beat. done is therefore
      // high during DONE, in the same cycle as that beat's write. By then
      // entry_count already includes the last entry.
      done               <= accept && in_last;

      if (start_tile) begin
        run_cnt       <= '0;
        entry_count   <= '0;
        oaram_address <= '0;
        overflow      <= 1'b0;
      end else if (accept) begin
        if (emit) begin
          run_cnt <= '0;
          if (full) begin
            // The entry is dropped. The address and count stay where they
            // are, and value/index keep their previous contents.
            overflow <= 1'b1;
          end else begin
            oaram_write_enable  <= 1'b1;
            oaram_value         <= relu_v;
            oaram_indices_value <= is_zero ? MAX_RUN : run_cnt;
            // The entry count before the increment is the write address.
            oaram_address       <= entry_count[RAM_WIDTH-1:0];
            entry_count         <= entry_count + 1'b1;
          end
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_oaram_encoder.sv
module tb_sparse_oaram_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start_a, start_b;
  logic       in_valid, in_last;
  logic [7:0] in_data;

  // dut_a: default geometry (DEPTH 1024); dut_b: RAM_WIDTH=2 (DEPTH 4)
  logic       in_ready_a, we_a, done_a, ovf_a;
  logic [7:0] val_a;
  logic [3:0] idx_a;
  logic [9:0] addr_a;
  logic [10:0] ec_a;
  logic [1:0] st_a;

  logic       in_ready_b, we_b, done_b, ovf_b;
  logic [7:0] val_b;
  logic [3:0] idx_b;
  logic [1:0] addr_b;
  logic [2:0] ec_b;
  logic [1:0] st_b;

  sparse_oaram_encoder dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .oaram_value(val_a), .oaram_indices_value(idx_a), .oaram_address(addr_a),
    .oaram_write_enable(we_a), .entry_count(ec_a), .done(done_a),
    .overflow(ovf_a), .state_dbg(st_a)
  );

  sparse_oaram_encoder #(.DATA_WIDTH(8), .INDEX_WIDTH(4), .RAM_WIDTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .oaram_value(val_b), .oaram_indices_value(idx_b), .oaram_address(addr_b),
    .oaram_write_enable(we_b), .entry_count(ec_b), .done(done_b),
    .overflow(ovf_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // entry packing: {value[7:0], index[3:0], address[9:0]}
  logic [21:0] exp_q_a[$];
  logic [21:0] exp_q_b[$];
  logic [21:0] e_a, e_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write_a: got write (%0d,%0d)@%0d expected none", val_a, idx_a, addr_a);
      end else begin
        e_a = exp_q_a.pop_front();
        check("wr_value_a", 32'(val_a), 32'(e_a[21:14]));
        check("wr_index_a", 32'(idx_a), 32'(e_a[13:10]));
        check("wr_addr_a",  32'(addr_a), 32'(e_a[9:0]));
      end
    end
    if (we_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write_b: got write (%0d,%0d)@%0d expected none", val_b, idx_b, addr_b);
      end else begin
        e_b = exp_q_b.pop_front();
        check("wr_value_b", 32'(val_b), 32'(e_b[21:14]));
        check("wr_index_b", 32'(idx_b), 32'(e_b[13:10]));
        check("wr_addr_b",  32'(addr_b), 32'(e_b[9:0]));
      end
    end
  end

  // ---------------- reference model ----------------
  int m_run, m_cnt, m_depth, tgt;
  int m_ovf;

  task automatic model_beat(input logic [7:0] d);
    int v;
    logic [21:0] ent;
    logic [3:0] ix;
    v = d[7] ? 0 : int'(d);
    if (v != 0 || m_run == 15) begin
      if (m_cnt < m_depth) begin
        ix  = (v != 0) ? 4'(m_run) : 4'hF;
        ent = {8'(v), ix, 10'(m_cnt)};
        if (tgt == 0) exp_q_a.push_back(ent);
        else          exp_q_b.push_back(ent);
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
      m_run = 0;
    end else begin
      m_run++;
    end
  endtask

  function automatic logic [31:0] cur_ec();
    return (tgt == 0) ? 32'(ec_a) : 32'(ec_b);
  endfunction
  function automatic logic [31:0] cur_done();
    return (tgt == 0) ? 32'(done_a) : 32'(done_b);
  endfunction
  function automatic logic [31:0] cur_ovf();
    return (tgt == 0) ? 32'(ovf_a) : 32'(ovf_b);
  endfunction
  function automatic logic [31:0] cur_ready();
    return (tgt == 0) ? 32'(in_ready_a) : 32'(in_ready_b);
  endfunction
  function automatic logic [31:0] cur_state();
    return (tgt == 0) ? 32'(st_a) : 32'(st_b);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start_a = 1'b1;
    else            start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic begin_tile(input int which, input int depth);
    tgt = which;
    pulse_start(which);
    m_run = 0; m_cnt = 0; m_ovf = 0; m_depth = depth;
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    check("in_ready_run", cur_ready(), 32'd1);
    @(posedge clk);
    model_beat(d);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  // Called right after the last beat's accepting edge.
  task automatic end_tile(input string tag);
    check({tag, "_done"},     cur_done(), 32'd1);
    check({tag, "_count"},    cur_ec(),   32'(m_cnt));
    check({tag, "_overflow"}, cur_ovf(),  32'(m_ovf));
    gap(1);
    check({tag, "_done_pulse"}, cur_done(),  32'd0);
    check({tag, "_idle"},       cur_state(), 32'd0);
    check({tag, "_count_hold"}, cur_ec(),    32'(m_cnt));
    check({tag, "_drained"},    32'(exp_q_a.size() + exp_q_b.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_val_a"},  32'(val_a), 0);
    check({tag, "_idx_a"},  32'(idx_a), 0);
    check({tag, "_addr_a"}, 32'(addr_a), 0);
    check({tag, "_we_a"},   32'(we_a), 0);
    check({tag, "_ec_a"},   32'(ec_a), 0);
    check({tag, "_done_a"}, 32'(done_a), 0);
    check({tag, "_ovf_a"},  32'(ovf_a), 0);
    check({tag, "_rdy_a"},  32'(in_ready_a), 0);
    check({tag, "_st_a"},   32'(st_a), 0);
    check({tag, "_ec_b"},   32'(ec_b), 0);
    check({tag, "_we_b"},   32'(we_b), 0);
  endtask

  // ---------------- single-beat ReLU table ----------------
  typedef struct {
    logic [7:0] data;
    bit         exp_we;
    logic [7:0] exp_val;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] d;
    reset_n = 1'b0; start_a = 0; start_b = 0;
    in_valid = 0; in_last = 0; in_data = 0;
    tgt = 0; m_run = 0; m_cnt = 0; m_depth = 1024; m_ovf = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    vecs[0] = '{8'd5,   1'b1, 8'd5,   1};
    vecs[1] = '{8'hFD,  1'b0, 8'd0,   0};
    vecs[2] = '{8'd127, 1'b1, 8'd127, 1};
    vecs[3] = '{8'h80,  1'b0, 8'd0,   0};
    vecs[4] = '{8'd0,   1'b0, 8'd0,   0};
    vecs[5] = '{8'd1,   1'b1, 8'd1,   1};
    for (int i = 0; i < 6; i++) begin
      begin_tile(0, 1024);
      send(vecs[i].data, 1'b1);
      check("tbl_we", 32'(we_a), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) check("tbl_value", 32'(val_a), 32'(vecs[i].exp_val));
      check("tbl_count", 32'(ec_a), 32'(vecs[i].exp_cnt));
      end_tile("tbl");
    end

    // [5, 0, 0, 7, -3 last]
    begin_tile(0, 1024);
    send(8'd5, 0); send(8'd0, 0); send(8'd0, 0); send(8'd7, 0); send(8'hFD, 1);
    end_tile("seq1");
    check("seq1_count_abs", 32'(ec_a), 32'd2);

    // 16 zeros then 9
    begin_tile(0, 1024);
    for (int i = 0; i < 16; i++) send(8'd0, 0);
    send(8'd9, 1);
    end_tile("seq2");
    check("seq2_count_abs", 32'(ec_a), 32'd2);

    // 40 zeros, last on the 40th
    begin_tile(0, 1024);
    for (int i = 0; i < 40; i++) send(8'd0, i == 39);
    end_tile("seq3");
    check("seq3_count_abs", 32'(ec_a), 32'd2);

    // small OARAM (DEPTH 4): 1..6, writes 0..3 only, overflow
    begin_tile(1, 4);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    end_tile("ovf");
    check("ovf_count_abs", 32'(ec_b), 32'd4);
    check("ovf_sticky",    32'(ovf_b), 32'd1);
    check("ovf_addr_hold", 32'(addr_b), 32'd3);

    // reset mid-tile, then a fresh tile [8]
    begin_tile(0, 1024);
    send(8'd5, 0); send(8'd0, 0); send(8'd3, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_drained", 32'(exp_q_a.size()), 32'd0);
    exp_q_a.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    begin_tile(0, 1024);
    send(8'd8, 1);
    check("rst_new_addr", 32'(addr_a), 32'd0);
    end_tile("rst_new");

    // start during RUN is ignored; gaps do not disturb run/address
    begin_tile(0, 1024);
    send(8'd6, 0);
    gap(2);
    send(8'd0, 0);
    pulse_start(0);
    gap(3);
    check("restart_ignored_count", 32'(ec_a), 32'd1);
    check("restart_ignored_state", 32'(st_a), 32'd1);
    send(8'd0, 0);
    send(8'd4, 1);
    check("restart_tail_index", 32'(idx_a), 32'd2);
    check("restart_tail_addr",  32'(addr_a), 32'd1);
    end_tile("restart");

    // random stream, zero-heavy, with random gaps
    begin_tile(0, 1024);
    for (int i = 0; i < 80; i++) begin
      d = ($urandom_range(0, 9) < 7) ? 8'd0 : 8'($urandom_range(0, 255));
      gap($urandom_range(0, 2));
      send(d, i == 79);
    end
    end_tile("rand");

    gap(2);
    check("final_drained", 32'(exp_q_a.size() + exp_q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
